// File: rtl/game_pkg.sv
// Shared definitions for the guessing game: alphabet size, blank code and the
// 7-segment letter ROM (active-low segments, bit 6 = g ... bit 0 = a).
package game_pkg;

    localparam int NUM_LETTERS = 21;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t LETTER_ROM [NUM_LETTERS] = '{
        7'b0001000, 7'b0000011, 7'b0100001, 7'b0000100, 7'b0001110,
        7'b0010000, 7'b0001011, 7'b1111001, 7'b1110001, 7'b0000010,
        7'b1000111, 7'b0000110, 7'b1001000, 7'b1000000, 7'b0001100,
        7'b1001110, 7'b0010010, 7'b0000111, 7'b1000001, 7'b0110000,
        7'b0100100
    };

    typedef enum logic [1:0] {
        DB_UP,
        DB_PRESS_WAIT,
        DB_DOWN,
        DB_RELEASE_WAIT
    } db_state_e;

    // Out-of-range indices show blank so a corrupted index never looks like a letter.
    function automatic seg_t letter_code(input logic [4:0] idx);
        if (idx < 5'(NUM_LETTERS)) return LETTER_ROM[idx];
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus four-state debouncer for one active-low key.
// level is high while the key is debounced-down; press pulses once per press.
module key_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic          sampled;
    db_state_e     state;
    logic [CW-1:0] cnt;

    assign sampled = sync[1];
    assign level   = (state == DB_DOWN) || (state == DB_RELEASE_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= 2'b11;
            state <= DB_UP;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            press <= 1'b0;
            case (state)
                DB_UP: begin
                    if (!sampled) begin
                        state <= DB_PRESS_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                DB_PRESS_WAIT: begin
                    if (sampled) begin
                        state <= DB_UP;
                        cnt   <= '0;
                    end else if (cnt >= LIMIT) begin
                        state <= DB_DOWN;
                        cnt   <= '0;
                        press <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DB_DOWN: begin
                    if (sampled) begin
                        state <= DB_RELEASE_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                DB_RELEASE_WAIT: begin
                    if (!sampled) begin
                        state <= DB_DOWN;
                        cnt   <= '0;
                    end else if (cnt >= LIMIT) begin
                        state <= DB_UP;
                        cnt   <= '0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= DB_UP;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/letter_entry.sv
// Letter selection front end: debounced next/prev with auto-repeat, a wrapping
// candidate index with live preview, and a held guess latched on submit.
module letter_entry
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_next_n,
    input  logic       key_prev_n,
    input  logic       key_submit_n,
    output logic [6:0] preview_seg,
    output logic [6:0] guess_seg,
    output logic       guess_valid,
    output logic [4:0] letter_idx
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(RPT_MAX) + 1;
    localparam logic [RW-1:0] DELAY_V = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RATE_V  = RW'(REPEAT_RATE);
    localparam logic [4:0]    LAST    = 5'(NUM_LETTERS - 1);

    // Bit 0 = next, bit 1 = prev.
    logic [1:0]    lvl;
    logic [1:0]    prs;
    logic [1:0]    fire;
    logic [1:0]    step;
    logic [1:0]    rep_first;
    logic [RW-1:0] rep_cnt [2];
    logic          submit_level;
    logic          submit_press;
    logic          unused_ok;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk(clk), .rst(rst), .key_n(key_next_n), .level(lvl[0]), .press(prs[0])
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk(clk), .rst(rst), .key_n(key_prev_n), .level(lvl[1]), .press(prs[1])
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_submit (
        .clk(clk), .rst(rst), .key_n(key_submit_n), .level(submit_level), .press(submit_press)
    );

    // Submit acts on the press edge only; holding it does nothing further.
    assign unused_ok = submit_level;

    // rep_cnt equals cycles since the press pulse (or since the last repeat);
    // a repeat fires when it reaches the delay first, then the rate.
    always_comb begin
        fire = '0;
        for (int i = 0; i < 2; i++) begin
            fire[i] = lvl[i] && !prs[i] && (rep_cnt[i] == (rep_first[i] ? DELAY_V : RATE_V));
        end
        step = prs | fire;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
            rep_first <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!lvl[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b1;
                end else if (prs[i]) begin
                    rep_cnt[i]   <= RW'(1);
                    rep_first[i] <= 1'b1;
                end else if (fire[i]) begin
                    rep_cnt[i]   <= RW'(1);
                    rep_first[i] <= 1'b0;
                end else if (rep_cnt[i] != '1) begin
                    rep_cnt[i] <= rep_cnt[i] + RW'(1);
                end
            end
        end
    end

    // guess_valid is a one-cycle strobe with no back-pressure: it marks the first
    // cycle a new guess_seg is presented, and guess_seg then holds until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            letter_idx  <= '0;
            guess_seg   <= SEG_BLANK;
            guess_valid <= 1'b0;
        end else begin
            guess_valid <= submit_press;
            if (submit_press) guess_seg <= letter_code(letter_idx);
            case (step)
                2'b01:   letter_idx <= (letter_idx == LAST) ? 5'd0 : letter_idx + 5'd1;
                2'b10:   letter_idx <= (letter_idx == 5'd0) ? LAST : letter_idx - 5'd1;
                default: letter_idx <= letter_idx;
            endcase
        end
    end

    assign preview_seg = letter_code(letter_idx);

endmodule

// File: tb/tb_letter_entry.sv
// Bench for letter_entry: directed key sequences, a run-length behavioural model
// checked every cycle, and hand-computed end-of-scenario expectations.
module tb_letter_entry;

    localparam int D     = 4;
    localparam int DELAY = 20;
    localparam int RATE  = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_next_n;
    logic       key_prev_n;
    logic       key_submit_n;
    logic [6:0] preview_seg;
    logic [6:0] guess_seg;
    logic       guess_valid;
    logic [4:0] letter_idx;

    int errors = 0;
    int checks = 0;
    int valid_seen = 0;

    logic [6:0] exp_rom [21] = '{
        7'b0001000, 7'b0000011, 7'b0100001, 7'b0000100, 7'b0001110,
        7'b0010000, 7'b0001011, 7'b1111001, 7'b1110001, 7'b0000010,
        7'b1000111, 7'b0000110, 7'b1001000, 7'b1000000, 7'b0001100,
        7'b1001110, 7'b0010010, 7'b0000111, 7'b1000001, 7'b0110000,
        7'b0100100
    };

    letter_entry #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(DELAY),
        .REPEAT_RATE(RATE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_next_n(key_next_n),
        .key_prev_n(key_prev_n),
        .key_submit_n(key_submit_n),
        .preview_seg(preview_seg),
        .guess_seg(guess_seg),
        .guess_valid(guess_valid),
        .letter_idx(letter_idx)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Key k goes debounced-down once D+1 consecutive synchronised low samples are
    // seen (and up again after D+1 high ones); steps happen on the press and then
    // whenever hold time t satisfies t >= DELAY and (t - DELAY) % RATE == 0.
    int         m_idx;
    logic [6:0] m_guess;
    bit         m_valid;
    bit         m_s1 [3];
    bit         m_s2 [3];
    bit         m_down [3];
    bit         m_press [3];
    int         m_run [3];
    int         m_hold [3];

    function automatic bit repeat_due(input int t);
        return (t >= DELAY) && (((t - DELAY) % RATE) == 0);
    endfunction

    task automatic model_reset();
        m_idx   = 0;
        m_guess = 7'b1111111;
        m_valid = 0;
        for (int i = 0; i < 3; i++) begin
            m_s1[i] = 1; m_s2[i] = 1; m_down[i] = 0; m_press[i] = 0;
            m_run[i] = 0; m_hold[i] = 0;
        end
    endtask

    task automatic model_step(input bit raw0, input bit raw1, input bit raw2);
        bit raw [3];
        bit smp;
        int delta;
        raw[0] = raw0; raw[1] = raw1; raw[2] = raw2;
        delta = 0;
        if (m_press[0] || (m_down[0] && repeat_due(m_hold[0]))) delta = delta + 1;
        if (m_press[1] || (m_down[1] && repeat_due(m_hold[1]))) delta = delta - 1;
        m_valid = m_press[2];
        if (m_press[2]) m_guess = exp_rom[m_idx];
        m_idx = (m_idx + delta + 21) % 21;
        for (int i = 0; i < 3; i++) begin
            smp = m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
            m_press[i] = 0;
            if (smp == m_down[i]) begin
                m_run[i]++;
                if (m_run[i] == D + 1) begin
                    m_down[i] = !m_down[i];
                    m_run[i] = 0;
                    m_press[i] = m_down[i];
                end
            end else begin
                m_run[i] = 0;
            end
            m_hold[i] = m_press[i] ? 0 : m_hold[i] + 1;
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(posedge clk) begin
        #1;
        if (!rst) model_reset();
        else model_step(key_next_n, key_prev_n, key_submit_n);
        if (guess_valid) valid_seen++;
        check("letter_idx", int'(letter_idx), m_idx);
        check("preview_seg", int'(preview_seg), int'(exp_rom[m_idx]));
        check("guess_seg", int'(guess_seg), int'(m_guess));
        check("guess_valid", int'(guess_valid), int'(m_valid));
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_keys(input bit nx, input bit pv, input bit sb, input int hold, input int gap);
        @(negedge clk);
        key_next_n   = !nx;
        key_prev_n   = !pv;
        key_submit_n = !sb;
        wait_cycles(hold);
        key_next_n   = 1'b1;
        key_prev_n   = 1'b1;
        key_submit_n = 1'b1;
        wait_cycles(gap);
    endtask

    // ---------------- stimulus ----------------
    int v0;

    initial begin
        rst          = 1'b0;
        key_next_n   = 1'b1;
        key_prev_n   = 1'b1;
        key_submit_n = 1'b1;
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(10);
        check("reset_idx", int'(letter_idx), 0);
        check("reset_preview", int'(preview_seg), 'b0001000);
        check("reset_guess", int'(guess_seg), 'b1111111);
        check("reset_valid_never", valid_seen, 0);

        // Two short glitches, then a clean hold: one step only.
        press_keys(1, 0, 0, 2, 3);
        press_keys(1, 0, 0, 2, 3);
        press_keys(1, 0, 0, 10, 15);
        check("glitch_idx", int'(letter_idx), 1);
        check("glitch_preview", int'(preview_seg), 'b0000011);

        press_keys(0, 1, 0, 8, 12);
        check("prev_to_0", int'(letter_idx), 0);
        press_keys(0, 1, 0, 8, 12);
        check("prev_wrap_idx", int'(letter_idx), 20);
        check("prev_wrap_preview", int'(preview_seg), 'b0100100);
        press_keys(1, 0, 0, 8, 12);
        check("next_wrap_idx", int'(letter_idx), 0);

        // 40-cycle hold: press step plus repeats at +20, +25, +30, +35.
        press_keys(1, 0, 0, 40, 15);
        check("autorepeat_idx", int'(letter_idx), 5);

        for (int i = 0; i < 8; i++) press_keys(1, 0, 0, 8, 12);
        check("step_to_13", int'(letter_idx), 13);
        v0 = valid_seen;
        press_keys(0, 0, 1, 8, 12);
        check("submit_guess", int'(guess_seg), 'b1000000);
        check("submit_one_pulse", valid_seen - v0, 1);
        wait_cycles(20);
        check("guess_held", int'(guess_seg), 'b1000000);

        press_keys(1, 1, 0, 8, 12);
        check("cancel_idx", int'(letter_idx), 13);

        for (int i = 0; i < 10; i++) press_keys(0, 1, 0, 8, 12);
        check("step_to_3", int'(letter_idx), 3);
        press_keys(1, 0, 1, 8, 12);
        check("submit_pre_step_guess", int'(guess_seg), 'b0000100);
        check("submit_with_next_idx", int'(letter_idx), 4);

        // Reset while next is held: state clears, and the still-held key must
        // debounce again before it steps.
        @(negedge clk);
        key_next_n = 1'b0;
        wait_cycles(10);
        rst = 1'b0;
        wait_cycles(2);
        check("midhold_reset_idx", int'(letter_idx), 0);
        check("midhold_reset_guess", int'(guess_seg), 'b1111111);
        rst = 1'b1;
        wait_cycles(10);
        key_next_n = 1'b1;
        wait_cycles(15);
        check("after_reset_press_idx", int'(letter_idx), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
